// File: rtl/pc_pkg.sv
// Shared branch encodings and FSM state definitions for the PC generator.
package pc_pkg;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_NE   = 3'b001;
   localparam logic [2:0] BR_EQ   = 3'b010;
   localparam logic [2:0] BR_JAL  = 3'b011;
   localparam logic [2:0] BR_JALR = 3'b100;

   typedef logic [0:0] state_t;

   localparam state_t ST_RUN       = 1'b0;
   localparam state_t ST_TRAP_WAIT = 1'b1;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [XLEN-1:0]              wdata,
   output logic [XLEN-1:0]              top,
   output logic                         valid,
   output logic [$clog2(RAS_DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] r_mem [RAS_DEPTH];
   logic [PW-1:0]   r_ptr;
   logic [CW-1:0]   r_count;

   logic            w_empty;
   logic            w_full;
   logic            w_replace;
   logic            w_do_push;
   logic            w_do_pop;
   logic [PW-1:0]   w_top_idx;
   logic [PW-1:0]   w_wr_idx;

   assign w_empty   = (r_count == CW'(0));
   assign w_full    = (r_count == CW'(RAS_DEPTH));
   assign w_top_idx = r_ptr - PW'(1);
   // Push+pop on a non-empty stack rewrites the top in place.
   assign w_replace = push & pop & ~w_empty;
   assign w_do_push = push & ~w_replace;
   assign w_do_pop  = pop & ~push & ~w_empty;
   assign w_wr_idx  = w_replace ? w_top_idx : r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (w_do_push) begin
         r_ptr   <= r_ptr + PW'(1);
         r_count <= w_full ? r_count : r_count + CW'(1);
      end else if (w_do_pop) begin
         r_ptr   <= w_top_idx;
         r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && rst_n) begin
         r_mem[w_wr_idx] <= wdata;
      end
   end

   assign top   = r_mem[w_top_idx];
   assign valid = ~w_empty;
   assign count = r_count;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with branch/jump targeting, misaligned-target trap and return-address prediction.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
   parameter int unsigned     RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            advance,
   input  logic [2:0]      branch,
   input  logic            zero,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] alu_out,
   input  logic            rd_link,
   input  logic            rs1_link,
   input  logic            trap_ack,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            trap_pending,
   output logic [XLEN-1:0] trap_addr,
   output logic [XLEN-1:0] ras_pred,
   output logic            ras_valid,
   output logic            ras_miss
);

   localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic            r_trap_pending;
   logic            w_trap_pending_nxt;
   logic [XLEN-1:0] r_trap_addr;
   logic [XLEN-1:0] w_trap_addr_nxt;
   logic            r_ras_miss;
   logic            w_ras_miss_nxt;

   logic [XLEN-1:0] w_pc_plus4;
   logic [XLEN-1:0] w_target;
   logic            w_taken;
   logic            w_is_jalr;
   logic            w_is_link;
   logic            w_misaligned;
   logic            w_retire;
   logic            w_ras_push;
   logic            w_ras_pop;
   logic [XLEN-1:0] w_ras_top;
   logic            w_ras_valid;
   logic [CW-1:0]   w_ras_count;

   // Target selection; reserved branch codes fall through to sequential.
   always_comb begin
      w_taken = 1'b0;
      case (branch)
         BR_NE:   w_taken = ~zero;
         BR_EQ:   w_taken = zero;
         BR_JAL:  w_taken = 1'b1;
         default: w_taken = 1'b0;
      endcase
   end

   assign w_pc_plus4   = r_pc + XLEN'(4);
   assign w_is_jalr    = (branch == BR_JALR);
   assign w_is_link    = (branch == BR_JAL) | w_is_jalr;
   assign w_target     = w_is_jalr ? {alu_out[XLEN-1:1], 1'b0}
                       : (w_taken ? r_pc + imm : w_pc_plus4);
   assign w_misaligned = |w_target[1:0];
   assign w_retire     = (r_state == ST_RUN) & advance & ~w_misaligned;
   assign w_ras_push   = w_retire & w_is_link & rd_link;
   assign w_ras_pop    = w_retire & w_is_jalr & rs1_link;

   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_ras_push),
      .pop   (w_ras_pop),
      .wdata (w_pc_plus4),
      .top   (w_ras_top),
      .valid (w_ras_valid),
      .count (w_ras_count)
   );

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt        = r_state;
      w_pc_nxt           = r_pc;
      w_trap_pending_nxt = r_trap_pending;
      w_trap_addr_nxt    = r_trap_addr;
      w_ras_miss_nxt     = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (advance) begin
               if (w_misaligned) begin
                  w_state_nxt        = ST_TRAP_WAIT;
                  w_pc_nxt           = TRAP_VEC;
                  w_trap_addr_nxt    = w_target;
                  w_trap_pending_nxt = 1'b1;
               end else begin
                  w_pc_nxt       = w_target;
                  w_ras_miss_nxt = w_ras_pop & (w_ras_count != CW'(0))
                                 & (w_ras_top != w_target);
               end
            end
         end
         ST_TRAP_WAIT: begin
            w_pc_nxt = TRAP_VEC;
            if (trap_ack) begin
               w_state_nxt        = ST_RUN;
               w_trap_pending_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt        = ST_RUN;
            w_trap_pending_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_RUN;
         r_pc           <= RESET_VEC;
         r_trap_pending <= 1'b0;
         r_trap_addr    <= '0;
         r_ras_miss     <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_pc           <= w_pc_nxt;
         r_trap_pending <= w_trap_pending_nxt;
         r_trap_addr    <= w_trap_addr_nxt;
         r_ras_miss     <= w_ras_miss_nxt;
      end
   end

   assign pc           = r_pc;
   assign pc_plus4     = w_pc_plus4;
   assign trap_pending = r_trap_pending;
   assign trap_addr    = r_trap_addr;
   assign ras_pred     = w_ras_top;
   assign ras_valid    = w_ras_valid;
   assign ras_miss     = r_ras_miss;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequencing, branches, traps, return stack and reset.
module tb_pc_gen;

   logic        clk;
   logic        rst_n;
   logic        advance;
   logic [2:0]  branch;
   logic        zero;
   logic [31:0] imm;
   logic [31:0] alu_out;
   logic        rd_link;
   logic        rs1_link;
   logic        trap_ack;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        trap_pending;
   logic [31:0] trap_addr;
   logic [31:0] ras_pred;
   logic        ras_valid;
   logic        ras_miss;

   int errors = 0;
   int checks = 0;

   pc_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .advance      (advance),
      .branch       (branch),
      .zero         (zero),
      .imm          (imm),
      .alu_out      (alu_out),
      .rd_link      (rd_link),
      .rs1_link     (rs1_link),
      .trap_ack     (trap_ack),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .trap_pending (trap_pending),
      .trap_addr    (trap_addr),
      .ras_pred     (ras_pred),
      .ras_valid    (ras_valid),
      .ras_miss     (ras_miss)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive(input logic adv, input logic [2:0] br, input logic z,
                        input logic [31:0] im, input logic [31:0] alu,
                        input logic rdl, input logic rsl, input logic ack);
      advance  = adv;
      branch   = br;
      zero     = z;
      imm      = im;
      alu_out  = alu;
      rd_link  = rdl;
      rs1_link = rsl;
      trap_ack = ack;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic apply_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic jump_to(input logic [31:0] addr);
      drive(1'b1, 3'b100, 1'b0, 32'h0, addr, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
      checks++; if (trap_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", trap_pending); end
      checks++; if (trap_addr !== 32'h0) begin errors++; $display("FAIL reset_trap_addr got=%h exp=0", trap_addr); end
      checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL reset_ras_valid got=%b exp=0", ras_valid); end
      checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL reset_ras_miss got=%b exp=0", ras_miss); end
      rst_n = 1'b1;
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_release_pc got=%h exp=0", pc); end
   endtask

   task automatic test_sequential();
      drive(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, 32'(4 * i)); end
      end
      checks++; if (pc_plus4 !== 32'h10) begin errors++; $display("FAIL seq_pc_plus4 got=%h exp=%h", pc_plus4, 32'h10); end
      idle();
      tick();
      checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq_hold got=%h exp=%h", pc, 32'hC); end
   endtask

   task automatic test_branch();
      jump_to(32'h40);
      checks++; if (pc !== 32'h40) begin errors++; $display("FAIL br_setup got=%h exp=%h", pc, 32'h40); end
      drive(1'b1, 3'b010, 1'b1, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc !== 32'h38) begin errors++; $display("FAIL br_eq_taken got=%h exp=%h", pc, 32'h38); end
      jump_to(32'h40);
      drive(1'b1, 3'b010, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc !== 32'h44) begin errors++; $display("FAIL br_eq_not_taken got=%h exp=%h", pc, 32'h44); end
      drive(1'b1, 3'b001, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc !== 32'h54) begin errors++; $display("FAIL br_ne_taken got=%h exp=%h", pc, 32'h54); end
      drive(1'b1, 3'b110, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc !== 32'h58) begin errors++; $display("FAIL br_reserved got=%h exp=%h", pc, 32'h58); end
      drive(1'b0, 3'b011, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc !== 32'h58) begin errors++; $display("FAIL br_no_advance got=%h exp=%h", pc, 32'h58); end
   endtask

   task automatic test_trap();
      drive(1'b1, 3'b100, 1'b0, 32'h0, 32'h103, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL trap_pc got=%h exp=%h", pc, 32'h100); end
      checks++; if (trap_addr !== 32'h102) begin errors++; $display("FAIL trap_addr got=%h exp=%h", trap_addr, 32'h102); end
      checks++; if (trap_pending !== 1'b1) begin errors++; $display("FAIL trap_pending got=%b exp=1", trap_pending); end
      drive(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL trap_wait_pc got=%h exp=%h", pc, 32'h100); end
      checks++; if (trap_pending !== 1'b1) begin errors++; $display("FAIL trap_wait_pending got=%b exp=1", trap_pending); end
      drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      checks++; if (trap_pending !== 1'b0) begin errors++; $display("FAIL trap_ack_pending got=%b exp=0", trap_pending); end
      checks++; if (pc !== 32'h100) begin errors++; $display("FAIL trap_ack_pc got=%h exp=%h", pc, 32'h100); end
      drive(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      checks++; if (pc !== 32'h104) begin errors++; $display("FAIL run_ack_ignored_pc got=%h exp=%h", pc, 32'h104); end
      checks++; if (trap_pending !== 1'b0) begin errors++; $display("FAIL run_ack_pending got=%b exp=0", trap_pending); end
      drive(1'b1, 3'b011, 1'b0, 32'h6, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (trap_addr !== 32'h10A) begin errors++; $display("FAIL jal_trap_addr got=%h exp=%h", trap_addr, 32'h10A); end
      checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL jal_trap_ras got=%b exp=0", ras_valid); end
      drive(1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
   endtask

   task automatic test_ras();
      logic [31:0] e;
      apply_reset();
      jump_to(32'h10);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 3'b011, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0);
         tick();
      end
      checks++; if (pc !== 32'h60) begin errors++; $display("FAIL ras_calls_pc got=%h exp=%h", pc, 32'h60); end
      checks++; if (ras_valid !== 1'b1) begin errors++; $display("FAIL ras_full_valid got=%b exp=1", ras_valid); end
      idle();
      tick();
      checks++; if (ras_pred !== 32'h54) begin errors++; $display("FAIL ras_hold_pred got=%h exp=%h", ras_pred, 32'h54); end
      for (int i = 0; i < 3; i++) begin
         e = 32'h54 - 32'(16 * i);
         checks++; if (ras_pred !== e) begin errors++; $display("FAIL ras_pred%0d got=%h exp=%h", i, ras_pred, e); end
         drive(1'b1, 3'b100, 1'b0, 32'h0, e, 1'b0, 1'b1, 1'b0);
         tick();
         checks++; if (pc !== e) begin errors++; $display("FAIL ras_ret_pc%0d got=%h exp=%h", i, pc, e); end
         checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL ras_hit_miss%0d got=%b exp=0", i, ras_miss); end
      end
      checks++; if (ras_pred !== 32'h24) begin errors++; $display("FAIL ras_last_pred got=%h exp=%h", ras_pred, 32'h24); end
      checks++; if (ras_valid !== 1'b1) begin errors++; $display("FAIL ras_last_valid got=%b exp=1", ras_valid); end
      drive(1'b1, 3'b100, 1'b0, 32'h0, 32'h200, 1'b0, 1'b1, 1'b0);
      tick();
      checks++; if (pc !== 32'h200) begin errors++; $display("FAIL ras_miss_pc got=%h exp=%h", pc, 32'h200); end
      checks++; if (ras_miss !== 1'b1) begin errors++; $display("FAIL ras_miss_pulse got=%b exp=1", ras_miss); end
      checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL ras_empty_valid got=%b exp=0", ras_valid); end
      idle();
      tick();
      checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL ras_miss_width got=%b exp=0", ras_miss); end
      drive(1'b1, 3'b100, 1'b0, 32'h0, 32'h80, 1'b0, 1'b1, 1'b0);
      tick();
      checks++; if (pc !== 32'h80) begin errors++; $display("FAIL ras_underflow_pc got=%h exp=%h", pc, 32'h80); end
      checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL ras_underflow_valid got=%b exp=0", ras_valid); end
      checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL ras_underflow_miss got=%b exp=0", ras_miss); end
   endtask

   task automatic test_replace();
      drive(1'b1, 3'b011, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (ras_pred !== 32'h84) begin errors++; $display("FAIL repl_push_pred got=%h exp=%h", ras_pred, 32'h84); end
      drive(1'b1, 3'b100, 1'b0, 32'h0, 32'h84, 1'b1, 1'b1, 1'b0);
      tick();
      checks++; if (pc !== 32'h84) begin errors++; $display("FAIL repl_pc got=%h exp=%h", pc, 32'h84); end
      checks++; if (ras_pred !== 32'hA4) begin errors++; $display("FAIL repl_pred got=%h exp=%h", ras_pred, 32'hA4); end
      checks++; if (ras_miss !== 1'b0) begin errors++; $display("FAIL repl_miss got=%b exp=0", ras_miss); end
      drive(1'b1, 3'b100, 1'b0, 32'h0, 32'hA4, 1'b0, 1'b1, 1'b0);
      tick();
      checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL repl_count got=%b exp=0", ras_valid); end
      drive(1'b1, 3'b100, 1'b0, 32'h0, 32'h200, 1'b1, 1'b1, 1'b0);
      tick();
      checks++; if (ras_valid !== 1'b1) begin errors++; $display("FAIL repl_empty_valid got=%b exp=1", ras_valid); end
      checks++; if (ras_pred !== 32'hA8) begin errors++; $display("FAIL repl_empty_pred got=%h exp=%h", ras_pred, 32'hA8); end
      idle();
   endtask

   task automatic test_wrap_and_reset();
      jump_to(32'hFFFF_FFFC);
      checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got=%h exp=0", pc_plus4); end
      drive(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", pc); end
      drive(1'b1, 3'b100, 1'b0, 32'h0, 32'h7, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (trap_pending !== 1'b1) begin errors++; $display("FAIL wrap_trap_pending got=%b exp=1", trap_pending); end
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_rst_pc got=%h exp=0", pc); end
      checks++; if (trap_pending !== 1'b0) begin errors++; $display("FAIL async_rst_pending got=%b exp=0", trap_pending); end
      checks++; if (ras_valid !== 1'b0) begin errors++; $display("FAIL async_rst_ras got=%b exp=0", ras_valid); end
      tick();
      rst_n = 1'b1;
      drive(1'b1, 3'b000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (pc !== 32'h4) begin errors++; $display("FAIL post_rst_run got=%h exp=%h", pc, 32'h4); end
      idle();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #2;
      test_reset();
      test_sequential();
      test_branch();
      test_trap();
      test_ras();
      test_replace();
      test_wrap_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
